// File: rtl/aer_pkg.sv
// Shared types for the AER replay/record path: timestamp width, replay states, event record.
package aer_pkg;

  localparam int unsigned TS_W       = 32;
  localparam int unsigned AER_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    EMIT
  } replay_state_t;

  typedef struct packed {
    logic [TS_W-1:0]       ts;
    logic [AER_ADDR_W-1:0] addr;
  } aer_event_t;

endpackage

// File: rtl/aer_ts_compare.sv
// Modular timestamp comparison: an event is due once now has reached it (within half the wrap range).
module aer_ts_compare
  import aer_pkg::*;
#(
  parameter int unsigned LATE_TOL = 100
) (
  input  logic [TS_W-1:0] now_ts,
  input  logic [TS_W-1:0] due_ts,
  output logic            due,
  output logic            late
);

  logic [TS_W-1:0] diff;

  always_comb begin
    diff = now_ts - due_ts;
    due  = ~diff[TS_W-1];
    late = due & (diff > LATE_TOL);
  end

endmodule

// File: rtl/aer_event_replayer.sv
// Holds one stored AER event until the us timer reaches its timestamp, then presents it downstream.
module aer_event_replayer
  import aer_pkg::*;
#(
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned LATE_TOL   = 100,
  parameter bit          DROP_LATE  = 1'b0,
  parameter int unsigned LATE_CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [TS_W-1:0]       time_stamp,
  input  logic                  enable,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [TS_W-1:0]       in_ts,
  input  logic [ADDR_W-1:0]     in_addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TS_W-1:0]       out_ts,
  output logic [ADDR_W-1:0]     out_addr,
  output logic [LATE_CNT_W-1:0] late_count,
  output logic                  busy
);

  replay_state_t         state_q, state_d;
  logic [TS_W-1:0]       hold_ts_q;
  logic [ADDR_W-1:0]     hold_addr_q;
  logic [LATE_CNT_W-1:0] late_cnt_q;
  logic                  due, late, accept, late_hit;

  aer_ts_compare #(.LATE_TOL(LATE_TOL)) u_cmp (
    .now_ts (time_stamp),
    .due_ts (hold_ts_q),
    .due    (due),
    .late   (late)
  );

  // in_ready is gated by rst_n so it reads 0 while reset is held
  always_comb begin
    in_ready = rst_n & enable & ~flush &
               ((state_q == IDLE) | ((state_q == EMIT) & out_ready));
    accept   = in_valid & in_ready;
    late_hit = 1'b0;
    state_d  = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (accept) state_d = WAIT;
        WAIT: begin
          if (due) begin
            late_hit = late;
            state_d  = (late && DROP_LATE) ? IDLE : EMIT;
          end
        end
        EMIT: if (out_ready) state_d = accept ? WAIT : IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_ts_q   <= '0;
      hold_addr_q <= '0;
      late_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        hold_ts_q   <= in_ts;
        hold_addr_q <= in_addr;
      end
      if (late_hit && (late_cnt_q != '1)) begin
        late_cnt_q <= late_cnt_q + LATE_CNT_W'(1);
      end
    end
  end

  assign out_valid  = (state_q == EMIT);
  assign out_ts     = hold_ts_q;
  assign out_addr   = hold_addr_q;
  assign late_count = late_cnt_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_aer_event_replayer.sv
// Bench for aer_event_replayer: two instances (emit-late and drop-late with narrow counter) share stimulus.
module tb_aer_event_replayer;
  import aer_pkg::*;

  localparam int unsigned TOL = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable, flush, in_valid, out_ready;
  logic [31:0] time_stamp, in_ts;
  logic [16:0] in_addr;

  logic        in_ready0, out_valid0, busy0;
  logic [31:0] out_ts0;
  logic [16:0] out_addr0;
  logic [15:0] lc0;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_ts1;
  logic [16:0] out_addr1;
  logic [2:0]  lc1;

  aer_event_replayer #(.ADDR_W(17), .LATE_TOL(TOL), .DROP_LATE(1'b0), .LATE_CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .time_stamp(time_stamp), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ts(in_ts), .in_addr(in_addr),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ts(out_ts0), .out_addr(out_addr0),
    .late_count(lc0), .busy(busy0)
  );

  aer_event_replayer #(.ADDR_W(17), .LATE_TOL(TOL), .DROP_LATE(1'b1), .LATE_CNT_W(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .time_stamp(time_stamp), .enable(enable), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready1), .in_ts(in_ts), .in_addr(in_addr),
    .out_valid(out_valid1), .out_ready(out_ready), .out_ts(out_ts1), .out_addr(out_addr1),
    .late_count(lc1), .busy(busy1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: one held event per instance, "holding" and "presenting" flags
  aer_event_t  m_ev[2]   = '{default: '0};
  bit          m_pend[2] = '{default: 1'b0};
  bit          m_pres[2] = '{default: 1'b0};
  int unsigned m_lc[2]   = '{default: 0};

  function automatic bit m_drop(int k);
    return (k == 1);
  endfunction

  function automatic int unsigned m_lcmax(int k);
    return (k == 0) ? 32'd65535 : 32'd7;
  endfunction

  function automatic bit exp_ready(int k);
    return rst_n && enable && !flush && (!m_pend[k] || (m_pres[k] && out_ready));
  endfunction

  function automatic int m_lag(int k);
    return int'(time_stamp - m_ev[k].ts);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_ev[k] <= '0; m_pend[k] <= 1'b0; m_pres[k] <= 1'b0; m_lc[k] <= 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (flush) begin
          m_pend[k] <= 1'b0; m_pres[k] <= 1'b0;
        end else if (m_pres[k]) begin
          if (out_ready) begin
            m_pres[k] <= 1'b0;
            m_pend[k] <= in_valid && exp_ready(k);
            if (in_valid && exp_ready(k)) begin
              m_ev[k].ts <= in_ts; m_ev[k].addr <= in_addr;
            end
          end
        end else if (m_pend[k]) begin
          if (m_lag(k) >= 0) begin
            if (m_lag(k) > int'(TOL)) begin
              if (m_lc[k] < m_lcmax(k)) m_lc[k] <= m_lc[k] + 1;
              if (m_drop(k)) m_pend[k] <= 1'b0;
              else m_pres[k] <= 1'b1;
            end else begin
              m_pres[k] <= 1'b1;
            end
          end
        end else if (in_valid && exp_ready(k)) begin
          m_pend[k] <= 1'b1; m_ev[k].ts <= in_ts; m_ev[k].addr <= in_addr;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("in_ready0", in_ready0, exp_ready(0));
    chk("out_valid0", out_valid0, m_pres[0]);
    chk("busy0", busy0, m_pend[0]);
    chk("late_count0", lc0, m_lc[0]);
    if (m_pres[0]) begin
      chk("out_ts0", out_ts0, m_ev[0].ts);
      chk("out_addr0", out_addr0, m_ev[0].addr);
    end
    chk("in_ready1", in_ready1, exp_ready(1));
    chk("out_valid1", out_valid1, m_pres[1]);
    chk("busy1", busy1, m_pend[1]);
    chk("late_count1", lc1, m_lc[1]);
    if (m_pres[1]) begin
      chk("out_ts1", out_ts1, m_ev[1].ts);
      chk("out_addr1", out_addr1, m_ev[1].addr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    time_stamp = time_stamp + 1;
  endtask

  // Leaves the caller at the first cycle out_valid0 is seen, 6 time units after the edge
  task automatic wait_out(input int budget, output bit got);
    got = 1'b0;
    for (int n = 0; n < budget && !got; n++) begin
      #4;
      if (out_valid0) got = 1'b1;
      else tick();
    end
  endtask

  bit got;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before finish");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; enable = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    time_stamp = '0; in_ts = '0; in_addr = '0;
    tick();
    chk("rst_out_valid", out_valid0, 0);
    chk("rst_in_ready", in_ready0, 0);
    chk("rst_out_ts", out_ts0, 0);
    chk("rst_busy", busy0, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: due exactly on time
    time_stamp = 32'd1000; in_ts = 32'd1005; in_addr = 17'h1ABCD; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(30, got);
    chk("t1_emitted", got, 1);
    chk("t1_ts_when_valid", time_stamp, 32'd1006);
    chk("t1_out_ts", out_ts0, 32'd1005);
    chk("t1_out_addr", out_addr0, 17'h1ABCD);
    chk("t1_dut1_valid", out_valid1, 1);
    tick();

    // T2: wait across the timer wrap
    time_stamp = 32'hFFFF_FFF0; in_ts = 32'h0000_0010; in_addr = 17'h00F01; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(80, got);
    chk("t2_emitted", got, 1);
    chk("t2_ts_when_valid", time_stamp, 32'h0000_0011);
    chk("t2_out_ts", out_ts0, 32'h0000_0010);
    tick();

    // T3: late event, emitted by dut0 and dropped by dut1
    time_stamp = 32'd500; in_ts = 32'd300; in_addr = 17'h12345; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #4;
    chk("t3_valid0", out_valid0, 1);
    chk("t3_late0", lc0, 1);
    chk("t3_valid1", out_valid1, 0);
    chk("t3_ready1", in_ready1, 1);
    chk("t3_busy1", busy1, 0);
    chk("t3_late1", lc1, 1);
    tick();

    // Tolerance boundary: lag 100 is on time, lag 101 is late
    time_stamp = 32'd700; in_ts = 32'd601; in_addr = 17'h00001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #4;
    chk("tol100_late0", lc0, 1);
    chk("tol100_valid1", out_valid1, 1);
    tick();
    time_stamp = 32'd700; in_ts = 32'd600; in_addr = 17'h00002; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #4;
    chk("tol101_late0", lc0, 2);
    chk("tol101_late1", lc1, 2);
    chk("tol101_valid1", out_valid1, 0);
    tick();

    // T4: backpressure then back-to-back accept
    out_ready = 1'b0;
    time_stamp = 32'd2000; in_ts = 32'd2001; in_addr = 17'h1F00F; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(10, got);
    chk("t4_emitted", got, 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      #4;
      chk("t4_hold_valid", out_valid0, 1);
      chk("t4_hold_addr", out_addr0, 17'h1F00F);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_ts = time_stamp + 32'd3; in_addr = 17'h00AA5;
    #1;
    chk("t4_b2b_ready0", in_ready0, 1);
    chk("t4_b2b_ready1", in_ready1, 1);
    tick();
    in_valid = 1'b0;
    #4;
    chk("t4_b2b_busy", busy0, 1);
    chk("t4_b2b_gap", out_valid0, 0);
    wait_out(10, got);
    chk("t4_second_addr", out_addr0, 17'h00AA5);
    tick();

    // enable low blocks accepts but not an event in flight
    enable = 1'b0; in_valid = 1'b1; in_ts = time_stamp; in_addr = 17'h0BEEF;
    tick();
    #4;
    chk("en_low_ready", in_ready0, 0);
    chk("en_low_busy", busy0, 0);
    tick();
    enable = 1'b1; in_ts = time_stamp + 32'd2;
    tick();
    enable = 1'b0; in_valid = 1'b0;
    wait_out(10, got);
    chk("en_low_completes", got, 1);
    chk("en_low_addr", out_addr0, 17'h0BEEF);
    tick();
    enable = 1'b1;

    // T5: flush while waiting on a far-future event
    time_stamp = 32'd5000; in_ts = 32'd105000; in_addr = 17'h00777; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    flush = 1'b1; in_valid = 1'b1;
    #4;
    chk("t5_flush_ready", in_ready0, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    #4;
    chk("t5_busy", busy0, 0);
    chk("t5_valid", out_valid0, 0);
    chk("t5_late0", lc0, 2);
    chk("t5_late1", lc1, 2);
    tick();

    // T6: async reset mid-EMIT
    out_ready = 1'b0;
    time_stamp = 32'd6000; in_ts = 32'd6001; in_addr = 17'h15555; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_out(10, got);
    chk("t6_emitting", got, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", out_valid0, 0);
    chk("t6_ready", in_ready0, 0);
    chk("t6_out_ts", out_ts0, 0);
    chk("t6_out_addr", out_addr0, 0);
    chk("t6_late0", lc0, 0);
    chk("t6_busy", busy0, 0);
    chk("t6_late1", lc1, 0);
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();

    // Saturation: dut1's 3-bit counter must stick at 7
    for (int i = 0; i < 9; i++) begin
      time_stamp = 32'h0001_0000; in_ts = 32'h0001_0000 - 32'd1000; in_addr = 17'(i);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();
      tick();
      if (i == 6) begin
        #4;
        chk("sat_reach_max", lc1, 7);
      end
    end
    #4;
    chk("sat_late0", lc0, 9);
    chk("sat_late1", lc1, 7);
    chk("sat_valid1", out_valid1, 0);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
